// File: rtl/adc_spi_master_if.sv
// adc_spi_master_if
// Sample handshake between the averaging acquisition stage and the ADC
// serial front end.
//   adc_data_req_i  conversion request, acquisition stage -> front end
//   adc_data_rdy_o  sample valid (level), front end -> acquisition stage
//   adc_data_o      12-bit sample, front end -> acquisition stage
//   adc_err_o       leading-zero violation flag, front end -> acquisition stage
// The _i/_o suffixes are named from the front end's point of view.
// Modports: master = acquisition stage, slave = adc_spi_master.
interface adc_spi_master_if;
  logic        adc_data_req_i;
  logic        adc_data_rdy_o;
  logic [11:0] adc_data_o;
  logic        adc_err_o;

  modport master (
    output adc_data_req_i,
    input  adc_data_rdy_o,
    input  adc_data_o,
    input  adc_err_o
  );

  modport slave (
    input  adc_data_req_i,
    output adc_data_rdy_o,
    output adc_data_o,
    output adc_err_o
  );
endinterface

// File: rtl/adc_spi_master.sv
// adc_spi_master
// Serial front end for a 12-bit SPI ADC with a 16-bit frame: 4 leading
// zeros, then 12 data bits, MSB first. One frame is run per rising edge of
// the request. The captured sample is then held with a level ready until
// the next request is accepted.
// Ports:
//   clk_i        system clock
//   reset_n_i    asynchronous active-low reset
//   bus          adc_spi_master_if.slave (req / rdy / data / err)
//   spi_cs_n_o   ADC chip select, active low
//   spi_sclk_o   ADC serial clock, idles high
//   spi_sdata_i  ADC serial data, changes after the SCLK falling edge
// Parameters:
//   CLK_DIV   SCLK half-period in clk_i cycles (>= 2)
//   CS_SETUP  cycles from CS_n falling to the first SCLK falling edge (>= 1)
//   T_QUIET   minimum CS_n-high cycles between frames (>= 1)
// Build option:
//   ADC_SPI_ZERO_CHECK_EN  when defined, adc_err_o flags a frame whose four
//                          leading bits were not all zero. When undefined,
//                          adc_err_o is tied low.
module adc_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int T_QUIET  = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  adc_spi_master_if.slave   bus,
  output logic              spi_cs_n_o,
  output logic              spi_sclk_o,
  input  logic              spi_sdata_i
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > T_QUIET) ? CLK_DIV : T_QUIET)
                           : ((CS_SETUP > T_QUIET) ? CS_SETUP : T_QUIET);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        req_d_q;
  logic        pending_q, pending_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        rdy_q, rdy_d;
  logic [11:0] data_q, data_d;
  logic        req_re;
  logic        start;
`ifdef ADC_SPI_ZERO_CHECK_EN
  logic        err_q, err_d;
`endif

  assign req_re = bus.adc_data_req_i & ~req_d_q;

  // State and datapath registers. req_d_q resets to 1 so that a request
  // held high through reset does not look like a fresh rising edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      req_d_q   <= 1'b1;
      pending_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      rdy_q     <= 1'b0;
      data_q    <= '0;
`ifdef ADC_SPI_ZERO_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      req_d_q   <= bus.adc_data_req_i;
      pending_q <= pending_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
`ifdef ADC_SPI_ZERO_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // Next-state and output logic. A request is accepted from IDLE, or
  // directly at the end of QUIET when one is already waiting, so a pending
  // request costs no extra idle cycle. In SHIFT the low phase ends by
  // sampling the ADC bit as SCLK is driven high. The high phase of bit 15
  // ends the frame by raising CS_n on the way into DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    rdy_d     = rdy_q;
    data_d    = data_q;
`ifdef ADC_SPI_ZERO_CHECK_EN
    err_d     = err_q;
`endif
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_re || pending_q) begin
          start = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1) | {15'd0, spi_sdata_i};
          end else if (bit_q == 4'd15) begin
            cs_n_d  = 1'b1;
            state_d = DONE;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        data_d  = shift_q[11:0];
        rdy_d   = 1'b1;
`ifdef ADC_SPI_ZERO_CHECK_EN
        err_d   = |shift_q[15:12];
`endif
        cnt_d   = '0;
        state_d = QUIET;
      end
      QUIET: begin
        if (cnt_q == CNT_W'(T_QUIET - 1)) begin
          cnt_d = '0;
          if (req_re || pending_q) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d = SETUP;
      cnt_d   = '0;
      bit_d   = '0;
      cs_n_d  = 1'b0;
      sclk_d  = 1'b1;
      rdy_d   = 1'b0;
`ifdef ADC_SPI_ZERO_CHECK_EN
      err_d   = 1'b0;
`endif
    end

    // Only one request can wait; further edges while one is pending are lost.
    if (start) begin
      pending_d = 1'b0;
    end else if (req_re && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
  end

  assign spi_cs_n_o         = cs_n_q;
  assign spi_sclk_o         = sclk_q;
  assign bus.adc_data_rdy_o = rdy_q;
  assign bus.adc_data_o     = data_q;
`ifdef ADC_SPI_ZERO_CHECK_EN
  assign bus.adc_err_o      = err_q;
`else
  assign bus.adc_err_o      = 1'b0;
`endif

endmodule
